// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the MIPS core.
// Shift-add multiply and restoring divide on magnitudes, signs fixed up in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iStart,
  input  logic [2:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCancel,
  output logic [WIDTH-1:0] oHI,
  output logic [WIDTH-1:0] oLO,
  output logic             oBusy,
  output logic             oDone,
  output logic             oDivZero
);

  // Handshake: iStart is sampled only in IDLE; oBusy is high in RUN/FIX;
  // oDone pulses for exactly one cycle after HI/LO were written.
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNTW-1:0]    cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, divzero_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mcand_q;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   shreg_q;   // multiplier, or dividend shifting into quotient
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   araw_q;
  logic               is_div_q, bzero_q, sgn_res_q, sgn_rem_q;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum_d;
  logic [2*WIDTH-1:0] acc_d, prod_neg_d;
  logic [WIDTH+1:0]   div_shift_d;
  logic               div_ge_d;
  logic [WIDTH:0]     rem_d;

  always_comb begin
    signed_op   = (iOp == OP_MULT) || (iOp == OP_DIV);
    a_neg       = signed_op && iA[WIDTH-1];
    b_neg       = signed_op && iB[WIDTH-1];
    a_mag       = a_neg ? -iA : iA;
    b_mag       = b_neg ? -iB : iB;
    mul_sum_d   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (shreg_q[0] ? mcand_q : {WIDTH{1'b0}})};
    acc_d       = {mul_sum_d, acc_q[WIDTH-1:1]};
    prod_neg_d  = -acc_q;
    div_shift_d = {rem_q, shreg_q[WIDTH-1]};
    div_ge_d    = div_shift_d >= {2'b00, mcand_q};
    rem_d       = div_ge_d ? (div_shift_d[WIDTH:0] - {1'b0, mcand_q}) : div_shift_d[WIDTH:0];
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      shreg_q   <= '0;
      rem_q     <= '0;
      araw_q    <= '0;
      is_div_q  <= 1'b0;
      bzero_q   <= 1'b0;
      sgn_res_q <= 1'b0;
      sgn_rem_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (iStart && !iCancel) begin
            case (iOp)
              OP_MTHI: begin
                hi_q      <= iA;
                done_q    <= 1'b1;
                divzero_q <= 1'b0;
              end
              OP_MTLO: begin
                lo_q      <= iA;
                done_q    <= 1'b1;
                divzero_q <= 1'b0;
              end
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                divzero_q <= 1'b0;
                is_div_q  <= (iOp == OP_DIV) || (iOp == OP_DIVU);
                bzero_q   <= (iB == '0);
                sgn_res_q <= a_neg ^ b_neg;
                sgn_rem_q <= a_neg;
                araw_q    <= iA;
                shreg_q   <= a_mag;
                mcand_q   <= b_mag;
                acc_q     <= '0;
                rem_q     <= '0;
                cnt_q     <= '0;
                state_q   <= S_RUN;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (iCancel) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (is_div_q) begin
              rem_q   <= rem_d;
              shreg_q <= {shreg_q[WIDTH-2:0], div_ge_d};
            end else begin
              acc_q   <= acc_d;
              shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
            end
            if (cnt_q == CNTW'(WIDTH - 1)) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          if (!iCancel) begin
            done_q <= 1'b1;
            if (!is_div_q) begin
              {hi_q, lo_q} <= sgn_res_q ? prod_neg_d : acc_q;
            end else if (bzero_q) begin
              hi_q      <= araw_q;
              lo_q      <= '1;
              divzero_q <= 1'b1;
            end else begin
              lo_q <= sgn_res_q ? -shreg_q : shreg_q;
              hi_q <= sgn_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oHI      = hi_q;
  assign oLO      = lo_q;
  assign oBusy    = (state_q != S_IDLE);
  assign oDone    = done_q;
  assign oDivZero = divzero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected {divzero,HI,LO}
// and busy length per operation, plus directed cancel/reset/handshake checks.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic         iCLK, iRST_n, iStart, iCancel;
  logic [2:0]   iOp;
  logic [W-1:0] iA, iB, oHI, oLO;
  logic         oBusy, oDone, oDivZero;

  logic [2*W:0] exp_q[$];
  int           exp_busy_q[$];
  logic [W-1:0] model_hi, model_lo;
  int           busy_run;
  int           n_vec, n_bad;

  muldiv_unit #(.WIDTH(W)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iStart(iStart), .iOp(iOp), .iA(iA), .iB(iB),
    .iCancel(iCancel), .oHI(oHI), .oLO(oLO), .oBusy(oBusy), .oDone(oDone),
    .oDivZero(oDivZero)
  );

  // clock / reset
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [2*W:0] got, input logic [2*W:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    longint         sa, sb;
    logic [W-1:0]   eh, el;
    logic           dz;
    dz = 1'b0;
    eh = model_hi;
    el = model_lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT: begin
        p = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
        {eh, el} = p;
      end
      OP_MULTU: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        {eh, el} = p;
      end
      OP_DIV, OP_DIVU: begin
        if (b == '0) begin
          eh = a; el = '1; dz = 1'b1;
        end else if (op == OP_DIV) begin
          el = W'(sa / sb); eh = W'(sa % sb);
        end else begin
          el = a / b; eh = a % b;
        end
      end
      OP_MTHI: eh = a;
      default: el = a;
    endcase
    model_hi = eh;
    model_lo = el;
    exp_q.push_back({dz, eh, el});
    exp_busy_q.push_back((op == OP_MTHI || op == OP_MTLO) ? 0 : W + 1);
  endtask

  // drivers: issue_now drives from the current negedge, issue waits one first
  task automatic issue_now(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit track);
    iStart = 1'b1; iOp = op; iA = a; iB = b;
    if (track) push_model(op, a, b);
    @(negedge iCLK);
    iStart = 1'b0; iOp = 3'b000;
  endtask

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit track);
    @(negedge iCLK);
    issue_now(op, a, b, track);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!oDone && n < 100) begin
      @(negedge iCLK);
      n++;
    end
    if (!oDone) chk("done_timeout", {{2*W{1'b0}}, oDone}, 1);
  endtask

  // scoreboard
  always @(negedge iCLK) begin
    if (!iRST_n) begin
      busy_run = 0;
    end else begin
      if (oDone) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", {{2*W{1'b0}}, oDone}, 0);
        end else begin
          chk("result", {oDivZero, oHI, oLO}, exp_q.pop_front());
          chk("busy_len", (2*W+1)'(busy_run), (2*W+1)'(exp_busy_q.pop_front()));
        end
      end
      if (oBusy) busy_run++;
      else busy_run = 0;
    end
  end

  initial begin
    logic [W-1:0] h0, l0, ra, rb;
    logic [2:0]   rop;
    n_vec = 0; n_bad = 0; busy_run = 0;
    model_hi = '0; model_lo = '0;
    iRST_n = 1'b0; iStart = 1'b0; iCancel = 1'b0; iOp = 3'b000; iA = '0; iB = '0;
    repeat (3) @(negedge iCLK);
    chk("reset_hilo", {1'b0, oHI, oLO}, '0);
    chk("reset_flags", {{2*W-2{1'b0}}, oBusy, oDone, oDivZero}, '0);
    iRST_n = 1'b1;

    issue(OP_MULT, 32'hFFFFFFFF, 32'd7, 1'b1);
    wait_done();
    chk("mult_m1x7", {1'b0, oHI, oLO}, {1'b0, 64'hFFFFFFFF_FFFFFFF9});
    chk("done_busy_low", {{2*W{1'b0}}, oBusy}, 0);
    @(negedge iCLK);
    chk("done_one_cycle", {{2*W{1'b0}}, oDone}, 0);

    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    wait_done();
    chk("multu_max", {1'b0, oHI, oLO}, {1'b0, 64'hFFFFFFFE_00000001});

    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_done();
    chk("div_m7_2", {1'b0, oHI, oLO}, {1'b0, 64'hFFFFFFFF_FFFFFFFD});

    // back-to-back issue from the oDone cycle
    issue_now(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_done();
    chk("div_min_m1", {1'b0, oHI, oLO}, {1'b0, 64'h00000000_80000000});

    // cancel at cycle 10 of a divide
    h0 = oHI; l0 = oLO;
    issue(OP_DIV, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge iCLK);
    iCancel = 1'b1;
    @(negedge iCLK);
    iCancel = 1'b0;
    chk("cancel_busy", {{2*W{1'b0}}, oBusy}, 0);
    chk("cancel_hilo", {1'b0, oHI, oLO}, {1'b0, h0, l0});
    repeat (40) @(negedge iCLK);
    chk("cancel_hilo_late", {1'b0, oHI, oLO}, {1'b0, h0, l0});

    // MTHI then MTLO on consecutive cycles
    @(negedge iCLK);
    iStart = 1'b1; iOp = OP_MTHI; iA = 32'h12345678;
    push_model(OP_MTHI, 32'h12345678, '0);
    @(negedge iCLK);
    chk("mt_busy0", {{2*W{1'b0}}, oBusy}, 0);
    iOp = OP_MTLO; iA = 32'h9ABCDEF0;
    push_model(OP_MTLO, 32'h9ABCDEF0, '0);
    @(negedge iCLK);
    chk("mt_busy1", {{2*W{1'b0}}, oBusy}, 0);
    iStart = 1'b0; iOp = 3'b000;
    @(negedge iCLK);
    chk("mt_hilo", {1'b0, oHI, oLO}, {1'b0, 64'h12345678_9ABCDEF0});

    // iStart mid-RUN is ignored
    h0 = oHI;
    issue(OP_MULT, 32'd3, 32'd5, 1'b1);
    repeat (5) @(negedge iCLK);
    iStart = 1'b1; iOp = OP_MTHI; iA = 32'hDEADBEEF;
    @(negedge iCLK);
    iStart = 1'b0; iOp = 3'b000;
    chk("midrun_start_hi", {1'b0, {W{1'b0}}, oHI}, {1'b0, {W{1'b0}}, h0});
    chk("midrun_busy", {{2*W{1'b0}}, oBusy}, 1);
    wait_done();

    // random back-to-back operations
    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 17));
        2: rb = -W'($urandom_range(1, 17));
        default: rb = $urandom;
      endcase
      issue_now(rop, ra, rb, 1'b1);
      wait_done();
    end

    // divide by zero then a normal divide clears the flag
    issue(OP_DIVU, 32'd100, 32'd0, 1'b1);
    wait_done();
    chk("divu_by0", {oDivZero, oHI, oLO}, {1'b1, 64'h00000064_FFFFFFFF});
    issue(OP_DIVU, 32'd100, 32'd7, 1'b1);
    chk("divzero_clear", {{2*W{1'b0}}, oDivZero}, 0);
    wait_done();
    chk("divu_100_7", {oDivZero, oHI, oLO}, {1'b0, 64'h00000002_0000000E});

    // asynchronous reset mid-RUN
    issue(OP_MULT, 32'h7, 32'h9, 1'b0);
    repeat (8) @(negedge iCLK);
    #2 iRST_n = 1'b0;
    #1;
    chk("async_rst_hilo", {1'b0, oHI, oLO}, '0);
    chk("async_rst_flags", {{2*W-2{1'b0}}, oBusy, oDone, oDivZero}, '0);
    @(negedge iCLK);
    iRST_n = 1'b1;
    model_hi = '0; model_lo = '0;
    issue(OP_MULTU, 32'h10000, 32'h10000, 1'b1);
    wait_done();
    repeat (3) @(negedge iCLK);
    chk("queue_drained", (2*W+1)'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit with HI/LO registers. It sits beside the ALU in the MIPS core and executes the MULT, MULTU, DIV, DIVU, MTHI and MTLO operations that the ALU control decode selects. It uses a start/busy/done handshake so the pipeline control can stall on MFHI/MFLO until the result is ready. HI and LO are always readable combinationally from their registers.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits. Must be at least 4.
- CNTW, $clog2(WIDTH)+1: iteration counter width (derived; do not override).

- iCLK  input  1  system clock; all state changes on the rising edge.
- iRST_n  input  1  reset, asynchronous and active-low.
- iStart  input  1  request pulse; sampled only in IDLE.
- iOp  input  3  operation: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
- iA  input  WIDTH  rs operand; dividend for divides; write data for MTHI/MTLO.
- iB  input  WIDTH  rt operand; divisor for divides.
- iCancel  input  1  abort the in-flight operation (pipeline flush).
- oHI  output  WIDTH  HI register.
- oLO  output  WIDTH  LO register.
- oBusy  output  1  high whenever the state is not IDLE.
- oDone  output  1  one-cycle pulse; HI/LO were updated at the preceding edge.
- oDivZero  output  1  sticky flag: the last completed divide had a zero divisor; cleared by the next accepted iStart.

## Operation
- Reset: state IDLE; oHI=0, oLO=0; oDone=0; oDivZero=0; counter=0; working registers=0.
- States: IDLE, RUN, FIX.
- IDLE with iStart=1:
  - MTHI or MTLO: write iA to HI or LO at this edge and pulse oDone next cycle. The state stays IDLE.
  - MULT/MULTU/DIV/DIVU: latch the operand magnitudes and the result signs, clear the accumulator, set counter=0, go to RUN.
  - Op none: ignored.
- Magnitudes and signs:
  - Signed ops (MULT, DIV) use absolute values, taken as WIDTH-bit unsigned, so the most negative value maps to 2^(WIDTH-1).
  - Product sign = sA^sB.
  - Quotient sign = sA^sB; remainder sign = sA.
  - Unsigned ops force both signs to 0.
- RUN (exactly WIDTH cycles; counter increments each cycle, leaves at counter=WIDTH-1):
  - Multiply: shift-add, one multiplier bit per cycle (LSB first), into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle (MSB first). Remainder register is WIDTH+1 bits.
- FIX (1 cycle) applies signs and writes the result, then returns to IDLE with oDone=1 for the next cycle.
  - Multiply: {HI,LO} = two's-complement negation of the 2*WIDTH product if its sign is set.
  - Divide: LO = quotient, HI = remainder, each negated if its sign is set.
  - Divide by zero: no trap. HI = iA as latched, LO = all ones, oDivZero=1. RUN is still taken so latency is constant.
  - Signed min / -1: LO = min, HI = 0. This results from the magnitude arithmetic and needs no special case.
- iStart while oBusy=1: ignored; no queuing.
- iCancel=1 in RUN or FIX: go to IDLE at that edge. HI/LO are left unchanged, no oDone, oDivZero unchanged. iCancel has priority over FIX's write.
- iCancel and iStart together in IDLE: iStart is ignored.
- Asynchronous reset mid-operation: every output returns to its reset value immediately; the operation is lost.

## Timing
- Edge E0 accepts iStart. oBusy is high from just after E0 until just after E0+WIDTH+1, i.e. WIDTH+1 cycles.
- HI/LO are written at edge E0+WIDTH+1. oDone is high during the cycle after that edge, and oBusy is already low in that cycle.
- A new iStart during the oDone cycle is accepted, giving a back-to-back issue rate of one operation per WIDTH+2 cycles.
- MTHI/MTLO: registers update at E0; oDone is high in the cycle after E0; oBusy stays 0.
- oHI/oLO change only at a write edge, a cancel has no effect on them, and reset clears them.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use WIDTH=32.
- Reset then MULT with iA=0xFFFFFFFF (-1), iB=7 -> oBusy for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF9, with oDone for one cycle.
- MULTU with iA=0xFFFFFFFF, iB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- Signed division cases:
  - DIV -7/2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 100/0 -> HI=100, LO=0xFFFFFFFF, oDivZero=1. The next accepted DIVU 100/7 gives LO=14, HI=2 and clears oDivZero.
- Issue DIV, assert iCancel at cycle 10 -> oBusy drops at the next edge, HI/LO keep their prior values, and no oDone.
- Handshake and register-write checks:
  - MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> both written, with two oDone pulses and oBusy always 0.
  - iStart asserted mid-RUN -> ignored.
  - iRST_n pulled low mid-RUN -> all outputs 0 asynchronously.
